// File: rtl/mm_checkpoint_monitor.sv
// -----------------------------------------------------------------------------
// mm_checkpoint_monitor
//
// Cycle-accurate performance monitor for the matmul firmware checkpoint word.
// The firmware drives a 16-bit code onto the GPIO path. START_CODE arms a
// measurement and END_CODE closes it. The monitor counts clocks from START to
// END. Every other code change seen while running is logged, together with the
// counter value at that moment, in a small first-word-fall-through event FIFO.
//
// Ports
//   axis_clk        single clock
//   axis_rst_n      asynchronous active-low reset
//   checkbits_i     checkpoint word (sampled once per clock)
//   clear_i         sync clear: IDLE, FIFO flushed, counters and sticky flags 0
//   evt_pop_i       consume the head event (ignored when empty)
//   evt_valid_o     FIFO not empty
//   evt_code_o      head event code (0 when empty)
//   evt_time_o      head event timestamp (0 when empty)
//   state_o         0 IDLE, 1 RUN, 2 DONE, 3 TOUT
//   total_cycles_o  latched START->END cycle count
//   evt_overflow_o  sticky: an event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module mm_checkpoint_monitor #(
    parameter logic [15:0]      START_CODE = 16'h00A5,
    parameter logic [15:0]      END_CODE   = 16'h005A,
    parameter int               CNT_W      = 32,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [CNT_W-1:0] TIMEOUT    = CNT_W'(250000000)
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic [15:0]      checkbits_i,
    input  logic             clear_i,
    input  logic             evt_pop_i,
    output logic             evt_valid_o,
    output logic [15:0]      evt_code_o,
    output logic [CNT_W-1:0] evt_time_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] total_cycles_o,
    output logic             evt_overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TOUT = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0]      code;
        logic [CNT_W-1:0] stamp;
    } evt_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [15:0] code_q;
    logic [15:0] prev_q;
    logic [1:0]  prime_q;   // prime_q[1]: both code_q and prev_q hold real samples

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            code_q  <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            code_q  <= checkbits_i;
            prev_q  <= code_q;
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // The zero left in prev_q by reset is not a real sample. Without the prime
    // gate, a START_CODE held across a reset would look like a fresh change
    // and re-arm the monitor.
    logic chg;
    logic is_start;
    logic is_end;
    assign chg      = prime_q[1] && (code_q != prev_q);
    assign is_start = chg && (code_q == START_CODE);
    assign is_end   = chg && (code_q == END_CODE);

    // ------------------------------------------------------------------
    // State, counter, FIFO pointers
    // ------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] total;
    logic             ovf;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    evt_t             mem [FIFO_DEPTH];

    logic empty;
    logic full;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    logic arm;      // (re)start a measurement: count from 0, flush the FIFO
    logic push;     // an event wants into the FIFO
    logic flush;
    logic do_pop;
    logic do_push;
    logic drop;

    always_comb begin
        arm  = 1'b0;
        push = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: arm = is_start;
            ST_RUN: begin
                // END is logged too; a repeated START restarts instead.
                if (is_end)        push = 1'b1;
                else if (is_start) arm  = 1'b1;
                else if (chg)      push = 1'b1;
            end
            default: ;
        endcase
        flush   = clear_i || arm;
        do_pop  = evt_pop_i && !empty && !flush;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = push && !flush && (!full || do_pop);
        drop    = push && !flush && full && !do_pop;
    end

    // ------------------------------------------------------------------
    // FSM and cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            total <= '0;
        end else if (clear_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            total <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (is_end) begin
                        state <= ST_DONE;
                        total <= cnt;
                    end else if (is_start) begin
                        cnt <= '0;
                    end else if ((TIMEOUT != '0) && (cnt == TO_LAST)) begin
                        // Counter freezes at TIMEOUT-1 for post-mortem.
                        state <= ST_TOUT;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_TOUT: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
                if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if (clear_i)   ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge axis_clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= '{code: code_q, stamp: cnt};
    end

    // ------------------------------------------------------------------
    // Outputs (head gated so an empty FIFO reads as zeros)
    // ------------------------------------------------------------------
    evt_t head;
    assign head           = mem[rd_ptr[PTR_W-1:0]];
    assign evt_valid_o    = !empty;
    assign evt_code_o     = empty ? 16'h0 : head.code;
    assign evt_time_o     = empty ? '0 : head.stamp;
    assign state_o        = state;
    assign total_cycles_o = total;
    assign evt_overflow_o = ovf;

endmodule

// File: tb/tb_mm_checkpoint_monitor.sv
module tb_mm_checkpoint_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cb = 16'h0;
    logic        clr = 1'b0;
    logic        pop = 1'b0;

    logic        v1, v2;
    logic [15:0] c1, c2;
    logic [31:0] t1, t2, tot1, tot2;
    logic [1:0]  s1, s2;
    logic        o1, o2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Main instance: default (effectively disabled) timeout.
    mm_checkpoint_monitor dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .checkbits_i(cb), .clear_i(clr),
        .evt_pop_i(pop), .evt_valid_o(v1), .evt_code_o(c1), .evt_time_o(t1),
        .state_o(s1), .total_cycles_o(tot1), .evt_overflow_o(o1)
    );

    // Short-timeout instance for the TOUT corner.
    mm_checkpoint_monitor #(.TIMEOUT(32'd50)) dut_to (
        .axis_clk(clk), .axis_rst_n(rst_n), .checkbits_i(cb), .clear_i(clr),
        .evt_pop_i(pop), .evt_valid_o(v2), .evt_code_o(c2), .evt_time_o(t2),
        .state_o(s2), .total_cycles_o(tot2), .evt_overflow_o(o2)
    );

    typedef struct {
        logic [15:0] code;
        int          n;
        logic [1:0]  st;
        logic        vld;
        logic [15:0] hcode;
        logic [31:0] htime;
        logic [31:0] total;
        logic        ovf;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic pulse_pop();
        pop = 1'b1;
        step(1);
        pop = 1'b0;
    endtask

    logic [15:0] exp_c [8];
    logic [31:0] exp_t [8];

    initial begin
        // Timestamp of a code driven D clocks after the START drive is D-1.
        vt[0]  = '{16'h0000,  3, 2'd0, 1'b0, 16'h00,   0,   0, 1'b0};
        vt[1]  = '{16'h00A5,  1, 2'd0, 1'b0, 16'h00,   0,   0, 1'b0};
        vt[2]  = '{16'h00A5,  1, 2'd1, 1'b0, 16'h00,   0,   0, 1'b0};
        vt[3]  = '{16'h00A5, 99, 2'd1, 1'b0, 16'h00,   0,   0, 1'b0};
        vt[4]  = '{16'h005A,  2, 2'd2, 1'b1, 16'h5A, 100, 100, 1'b0};
        vt[5]  = '{16'h0000,  3, 2'd2, 1'b1, 16'h5A, 100, 100, 1'b0};
        vt[6]  = '{16'h00A5,  2, 2'd1, 1'b0, 16'h00,   0, 100, 1'b0};
        vt[7]  = '{16'h00A5, 39, 2'd1, 1'b0, 16'h00,   0, 100, 1'b0};
        vt[8]  = '{16'h0050,  2, 2'd1, 1'b1, 16'h50,  40, 100, 1'b0};
        vt[9]  = '{16'h0050, 48, 2'd1, 1'b1, 16'h50,  40, 100, 1'b0};
        vt[10] = '{16'h005A,  2, 2'd2, 1'b1, 16'h50,  40,  90, 1'b0};

        // Reset state
        #12;
        chk("rst.state", 32'(s1), 0);
        chk("rst.valid", 32'(v1), 0);
        chk("rst.total", tot1, 0);
        chk("rst.ovf",   32'(o1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // T1 / T2 table
        for (int i = 0; i < 11; i++) begin
            cb = vt[i].code;
            step(vt[i].n);
            chk($sformatf("vec%0d.state", i), 32'(s1),  32'(vt[i].st));
            chk($sformatf("vec%0d.valid", i), 32'(v1),  32'(vt[i].vld));
            chk($sformatf("vec%0d.code",  i), 32'(c1),  32'(vt[i].hcode));
            chk($sformatf("vec%0d.time",  i), t1,       vt[i].htime);
            chk($sformatf("vec%0d.total", i), tot1,     vt[i].total);
            chk($sformatf("vec%0d.ovf",   i), 32'(o1),  32'(vt[i].ovf));
        end
        pulse_pop();
        chk("t2.pop1.code", 32'(c1), 32'h5A);
        chk("t2.pop1.time", t1, 90);
        pulse_pop();
        chk("t2.pop2.valid", 32'(v1), 0);
        pulse_pop();   // pop while empty
        chk("t2.pop3.valid", 32'(v1), 0);
        chk("t2.pop3.state", 32'(s1), 2);

        // T3: overflow, and pop+push while full
        pulse_clear();
        chk("t3.clr.state", 32'(s1), 0);
        chk("t3.clr.total", tot1, 0);
        chk("t3.clr.valid", 32'(v1), 0);
        cb = 16'h0000; step(3);
        cb = 16'h00A5; step(2);
        for (int i = 1; i <= 8; i++) begin
            cb = 16'(i);
            step(1);
        end
        step(1);
        chk("t3.full.code", 32'(c1), 1);
        chk("t3.full.time", t1, 1);
        chk("t3.full.ovf",  32'(o1), 0);
        cb = 16'h0009; step(1);
        pulse_pop();
        chk("t3.pp.ovf",  32'(o1), 0);
        chk("t3.pp.code", 32'(c1), 2);
        cb = 16'h000A; step(2);
        chk("t3.drop.ovf",  32'(o1), 1);
        chk("t3.drop.code", 32'(c1), 2);
        for (int k = 0; k < 7; k++) begin
            exp_c[k] = 16'(k + 2);
            exp_t[k] = 32'(k + 2);
        end
        exp_c[7] = 16'h0009;
        exp_t[7] = 32'd10;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3.drain%0d.code", k), 32'(c1), 32'(exp_c[k]));
            chk($sformatf("t3.drain%0d.time", k), t1, exp_t[k]);
            pulse_pop();
        end
        chk("t3.drained.valid", 32'(v1), 0);
        chk("t3.drained.ovf",   32'(o1), 1);

        // T4: timeout (TIMEOUT=50 instance)
        pulse_clear();
        cb = 16'h0000; step(3);
        cb = 16'h00A5; step(51);
        chk("t4.pre.state", 32'(s2), 1);
        step(1);
        chk("t4.tout.state", 32'(s2), 3);
        chk("t4.main.state", 32'(s1), 1);
        step(10);
        cb = 16'h005A; step(3);
        chk("t4.sticky.state", 32'(s2), 3);
        chk("t4.sticky.total", tot2, 0);
        pulse_clear();
        chk("t4.clr.state", 32'(s2), 0);
        chk("t4.clr.ovf",   32'(o2), 0);
        chk("t4.clr.valid", 32'(v2), 0);
        chk("t4.clr.total", tot2, 0);
        step(5);
        chk("t4.idle.state", 32'(s2), 0);

        // T5: restart mid-run
        pulse_clear();
        cb = 16'h0000; step(3);
        cb = 16'h00A5; step(29);
        cb = 16'h0033; step(2);
        chk("t5.mid.code", 32'(c1), 32'h33);
        cb = 16'h00A5; step(21);
        chk("t5.restart.valid", 32'(v1), 0);
        cb = 16'h005A; step(2);
        chk("t5.state", 32'(s1), 2);
        chk("t5.total", tot1, 20);
        chk("t5.code",  32'(c1), 32'h5A);
        chk("t5.time",  t1, 20);
        pulse_pop();
        chk("t5.empty", 32'(v1), 0);

        // T6: async reset mid-run
        cb = 16'h0066; step(2);
        cb = 16'h00A5; step(3);
        chk("t6.run.state", 32'(s1), 1);
        chk("t6.run.total", tot1, 20);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6.rst.state", 32'(s1), 0);
        chk("t6.rst.total", tot1, 0);
        chk("t6.rst.valid", 32'(v1), 0);
        chk("t6.rst.ovf",   32'(o1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(10);
        chk("t6.held.state",    32'(s1), 0);
        chk("t6.held.state_to", 32'(s2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
